// File: rtl/alu_driver.sv
// Bus-functional ALU initiator: drives func/a/b for one DRIVE cycle, checks result, queues response.
// Accept-to-response 2 cycles when the FIFO is empty; cmd_ready drops when the response FIFO is full.
module alu_driver #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_func,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  output logic [1:0]           alu_func,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic [WIDTH-1:0]     alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic [1:0]           rsp_func,
  output logic                 rsp_mismatch,
  output logic [CNT_WIDTH-1:0] txn_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [1:0]       func;
    logic             mismatch;
  } rsp_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_alu_func;
  logic [WIDTH-1:0]     r_alu_a;
  logic [WIDTH-1:0]     r_alu_b;
  rsp_t                 r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic [CNT_WIDTH-1:0] r_txn_count;
  logic [CNT_WIDTH-1:0] r_err_count;

  logic                 w_not_full;
  logic                 w_cmd_ready;
  logic                 w_busy;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_rsp_valid;
  logic                 w_mismatch;
  logic [WIDTH-1:0]     w_expected;
  rsp_t                 w_push_dat;
  rsp_t                 w_head;

  assign w_not_full = (r_count < (AW+1)'(FIFO_DEPTH));

  // reset gates the handshake so nothing is admitted while reset is held low
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_busy      = 1'b0;
    w_accept    = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = reset && w_not_full;
        if (cmd_valid && w_cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        w_busy      = reset;
        w_push      = reset;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_alu_func <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
    end else if (w_accept) begin
      r_alu_func <= cmd_func;
      r_alu_a    <= cmd_a;
      r_alu_b    <= cmd_b;
    end
  end

  always_comb begin
    w_expected = '0;
    case (r_alu_func)
      2'd0:    w_expected = r_alu_a + r_alu_b;
      2'd1:    w_expected = r_alu_a - r_alu_b;
      2'd2:    w_expected = r_alu_a | r_alu_b;
      default: w_expected = r_alu_a & r_alu_b;
    endcase
  end

  assign w_mismatch = (alu_result != w_expected);
  assign w_push_dat = {alu_result, r_alu_func, w_mismatch};

  // first-word-fall-through response queue; empty reads back as zero
  assign w_head      = r_mem[r_rd_ptr];
  assign w_rsp_valid = (r_count != '0);
  assign w_pop       = w_rsp_valid && rsp_ready;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_txn_count <= '0;
      r_err_count <= '0;
    end else if (w_push) begin
      r_txn_count <= r_txn_count + CNT_WIDTH'(1);
      if (w_mismatch && (r_err_count != '1)) begin
        r_err_count <= r_err_count + CNT_WIDTH'(1);
      end
    end
  end

  assign cmd_ready    = w_cmd_ready;
  assign busy         = w_busy;
  assign alu_func     = r_alu_func;
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign rsp_valid    = w_rsp_valid;
  assign rsp_result   = w_rsp_valid ? w_head.result   : '0;
  assign rsp_func     = w_rsp_valid ? w_head.func     : 2'b00;
  assign rsp_mismatch = w_rsp_valid ? w_head.mismatch : 1'b0;
  assign txn_count    = r_txn_count;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: directed plan items plus randomized traffic against a queue-based model.
module tb_alu_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic        fault;

  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_func;
  logic [31:0] cmd_a, cmd_b;
  logic [1:0]  alu_func;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        rsp_valid, rsp_ready, rsp_mismatch, busy;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_func;
  logic [15:0] txn_count, err_count;

  logic        s_cmd_valid, s_cmd_ready;
  logic [1:0]  s_cmd_func;
  logic [31:0] s_cmd_a, s_cmd_b;
  logic [1:0]  s_alu_func;
  logic [31:0] s_alu_a, s_alu_b, s_alu_result;
  logic        s_rsp_valid, s_rsp_ready, s_rsp_mismatch, s_busy;
  logic [31:0] s_rsp_result;
  logic [1:0]  s_rsp_func;
  logic [1:0]  s_txn_count, s_err_count;

  typedef struct {
    logic [31:0] r;
    logic [1:0]  f;
    logic        m;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_txn, m_err;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        dr_busy, dr_rdy;

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_alu(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // ALU stand-ins: main one can be made faulty, the small-counter one always is
  assign alu_result   = ref_alu(alu_func, alu_a, alu_b) + (fault ? 32'd1 : 32'd0);
  assign s_alu_result = ref_alu(s_alu_func, s_alu_a, s_alu_b) + 32'd1;

  alu_driver #(.WIDTH(32), .FIFO_DEPTH(4), .CNT_WIDTH(16)) u_dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_func(rsp_func),
    .rsp_mismatch(rsp_mismatch), .txn_count(txn_count), .err_count(err_count), .busy(busy)
  );

  alu_driver #(.WIDTH(32), .FIFO_DEPTH(4), .CNT_WIDTH(2)) u_small (
    .clock(clock), .reset(reset),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_func(s_cmd_func), .cmd_a(s_cmd_a), .cmd_b(s_cmd_b),
    .alu_func(s_alu_func), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_result(s_alu_result),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_result(s_rsp_result), .rsp_func(s_rsp_func),
    .rsp_mismatch(s_rsp_mismatch), .txn_count(s_txn_count), .err_count(s_err_count), .busy(s_busy)
  );

  // Called at a negedge; returns at the negedge after the response push.
  task automatic send(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input logic flt);
    int w;
    exp_t e;
    fault = flt; cmd_func = f; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    n_checks++;
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL send_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, w);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    dr_busy = busy;
    dr_rdy = cmd_ready;
    cmd_a = ~a; cmd_b = ~b; cmd_func = ~f;
    e.r = ref_alu(f, a, b) + (flt ? 32'd1 : 32'd0);
    e.f = f;
    e.m = flt;
    exp_q.push_back(e);
    m_txn = m_txn + 16'd1;
    if (flt && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    @(negedge clock);
  endtask

  // Called at a negedge; pops the head and compares it with the model.
  task automatic pop_one();
    int w;
    exp_t e;
    w = 0;
    while (!rsp_valid && w < 50) begin
      @(negedge clock);
      w++;
    end
    n_checks++;
    if (!rsp_valid || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL pop_wait: rsp_valid=%b model_depth=%0d, required valid with model entry", rsp_valid, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    if ({rsp_result, rsp_func, rsp_mismatch} !== {e.r, e.f, e.m}) begin
      n_fail++;
      $display("FAIL pop_data: got result=%h func=%0d mm=%b, required result=%h func=%0d mm=%b",
               rsp_result, rsp_func, rsp_mismatch, e.r, e.f, e.m);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b, required 0", cmd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++; if ({rsp_valid, rsp_result, rsp_func, rsp_mismatch} !== 36'd0) begin n_fail++; $display("FAIL reset_rsp: got valid=%b result=%h, required all 0", rsp_valid, rsp_result); end
    n_checks++; if ({txn_count, err_count} !== 32'd0) begin n_fail++; $display("FAIL reset_counters: got txn=%0d err=%0d, required 0 0", txn_count, err_count); end
    n_checks++; if ({alu_func, alu_a, alu_b} !== 66'd0) begin n_fail++; $display("FAIL reset_alu: got func=%0d a=%h b=%h, required 0", alu_func, alu_a, alu_b); end
    n_checks++; if ({s_txn_count, s_err_count} !== 4'd0) begin n_fail++; $display("FAIL reset_small_counters: got %0d %0d, required 0 0", s_txn_count, s_err_count); end
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b, required 1", cmd_ready); end
  endtask

  task automatic test_add();
    cmd_func = 2'd0; cmd_a = 32'd2; cmd_b = 32'd3; cmd_valid = 1'b1; fault = 1'b0;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    n_checks++; if ({busy, cmd_ready, rsp_valid} !== 3'b100) begin n_fail++; $display("FAIL add_drive: busy/ready/valid=%b, required 100", {busy, cmd_ready, rsp_valid}); end
    n_checks++; if ({alu_func, alu_a, alu_b} !== {2'd0, 32'd2, 32'd3}) begin n_fail++; $display("FAIL add_alu_in: got a=%h b=%h, required 2 3", alu_a, alu_b); end
    @(negedge clock);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency: rsp_valid=%b 2 cycles after accept, required 1", rsp_valid); end
    n_checks++; if ({rsp_result, rsp_func, rsp_mismatch} !== {32'd5, 2'd0, 1'b0}) begin n_fail++; $display("FAIL add_rsp: got %h/%0d/%b, required 5/0/0", rsp_result, rsp_func, rsp_mismatch); end
    n_checks++; if (txn_count !== 16'd1) begin n_fail++; $display("FAIL add_txn: got %0d, required 1", txn_count); end
    m_txn = 16'd1;
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    n_checks++; if ({rsp_valid, rsp_result} !== 33'd0) begin n_fail++; $display("FAIL add_empty: valid=%b result=%h, required 0 0", rsp_valid, rsp_result); end
  endtask

  task automatic test_sequence();
    send(2'd0, 32'd5, 32'd3, 1'b0);
    n_checks++; if ({dr_busy, dr_rdy} !== 2'b10) begin n_fail++; $display("FAIL seq_drive1: busy/ready=%b, required 10", {dr_busy, dr_rdy}); end
    n_checks++; if ({alu_func, alu_a} !== {2'd0, 32'd5}) begin n_fail++; $display("FAIL seq_alu_hold: got func=%0d a=%h, required 0 5", alu_func, alu_a); end
    send(2'd3, 32'd1, 32'd3, 1'b0);
    n_checks++; if ({dr_busy, dr_rdy} !== 2'b10) begin n_fail++; $display("FAIL seq_drive2: busy/ready=%b, required 10", {dr_busy, dr_rdy}); end
    n_checks++; if (rsp_result !== 32'd8) begin n_fail++; $display("FAIL seq_first: got %0d, required 8", rsp_result); end
    pop_one();
    n_checks++; if (rsp_result !== 32'd1) begin n_fail++; $display("FAIL seq_second: got %0d, required 1", rsp_result); end
    pop_one();
    n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL seq_err: got %0d, required 0", err_count); end
  endtask

  task automatic test_wrap();
    send(2'd1, 32'd0, 32'd1, 1'b0);
    n_checks++; if ({rsp_result, rsp_mismatch} !== {32'hFFFF_FFFF, 1'b0}) begin n_fail++; $display("FAIL wrap_sub: got %h mm=%b, required ffffffff 0", rsp_result, rsp_mismatch); end
    pop_one();
    send(2'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    n_checks++; if ({rsp_result, rsp_mismatch} !== {32'd0, 1'b0}) begin n_fail++; $display("FAIL wrap_add: got %h mm=%b, required 0 0", rsp_result, rsp_mismatch); end
    pop_one();
  endtask

  task automatic test_backpressure();
    logic [31:0] last_a;
    logic [31:0] a5, b5;
    logic [1:0]  f5;
    exp_t        e;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      last_a = $urandom;
      send(2'($urandom_range(0, 3)), last_a, $urandom, 1'b0);
    end
    f5 = 2'($urandom_range(0, 3)); a5 = $urandom; b5 = $urandom;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_func = 2'($urandom_range(0, 3)); cmd_a = $urandom; cmd_b = $urandom;
      @(negedge clock);
      n_checks++; if ({cmd_ready, busy} !== 2'b00) begin n_fail++; $display("FAIL full_ready: cycle %0d ready/busy=%b, required 00", i, {cmd_ready, busy}); end
      n_checks++; if (alu_a !== last_a) begin n_fail++; $display("FAIL full_alu_hold: got %h, required %h", alu_a, last_a); end
    end
    cmd_func = f5; cmd_a = a5; cmd_b = b5;
    pop_one();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready: got %b, required 1", cmd_ready); end
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_fifth_accept: busy=%b, required 1", busy); end
    e.r = ref_alu(f5, a5, b5); e.f = f5; e.m = 1'b0;
    exp_q.push_back(e);
    m_txn = m_txn + 16'd1;
    // first pop lands on the same edge as the fifth push
    for (int i = 0; i < 4; i++) pop_one();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: rsp_valid=%b, required 0", rsp_valid); end
  endtask

  task automatic test_fault();
    send(2'd0, 32'd2, 32'd3, 1'b1);
    n_checks++; if ({rsp_result, rsp_mismatch} !== {32'd6, 1'b1}) begin n_fail++; $display("FAIL fault_rsp: got %0d mm=%b, required 6 1", rsp_result, rsp_mismatch); end
    n_checks++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL fault_err: got %0d, required 1", err_count); end
    pop_one();
    fault = 1'b0;
  endtask

  task automatic test_small_cnt();
    int w;
    logic [1:0]  f;
    logic [31:0] a, b;
    s_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      s_cmd_func = f; s_cmd_a = a; s_cmd_b = b; s_cmd_valid = 1'b1;
      w = 0;
      while (!s_cmd_ready && w < 20) begin @(negedge clock); w++; end
      @(posedge clock);
      @(negedge clock);
      s_cmd_valid = 1'b0;
      @(negedge clock);
      n_checks++; if ({s_rsp_valid, s_rsp_result, s_rsp_mismatch} !== {1'b1, ref_alu(f, a, b) + 32'd1, 1'b1}) begin n_fail++; $display("FAIL small_rsp: txn %0d got v=%b %h mm=%b", i, s_rsp_valid, s_rsp_result, s_rsp_mismatch); end
      n_checks++; if (s_txn_count !== 2'((i + 1) % 4)) begin n_fail++; $display("FAIL small_txn: txn %0d got %0d, required %0d", i, s_txn_count, (i + 1) % 4); end
      n_checks++; if (s_err_count !== 2'((i + 1 > 3) ? 3 : i + 1)) begin n_fail++; $display("FAIL small_err: txn %0d got %0d, required %0d", i, s_err_count, (i + 1 > 3) ? 3 : i + 1); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 4 || (exp_q.size() > 0 && $urandom_range(0, 2) == 0)) pop_one();
      send(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 3) == 0));
    end
    fault = 1'b0;
    while (exp_q.size() > 0) pop_one();
    n_checks++; if (txn_count !== m_txn) begin n_fail++; $display("FAIL rand_txn: got %0d, required %0d", txn_count, m_txn); end
    n_checks++; if (err_count !== m_err) begin n_fail++; $display("FAIL rand_err: got %0d, required %0d", err_count, m_err); end
  endtask

  task automatic test_reset_mid_drive();
    logic seen_valid;
    cmd_func = 2'd2; cmd_a = $urandom; cmd_b = $urandom; cmd_valid = 1'b1; fault = 1'b0;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b, required 1", busy); end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    n_checks++; if ({rsp_valid, txn_count, err_count} !== 33'd0) begin n_fail++; $display("FAIL mid_state: valid=%b txn=%0d err=%0d, required 0", rsp_valid, txn_count, err_count); end
    n_checks++; if ({alu_func, alu_a, alu_b} !== 66'd0) begin n_fail++; $display("FAIL mid_alu: a=%h b=%h, required 0", alu_a, alu_b); end
    reset = 1'b1;
    m_txn = 16'd0; m_err = 16'd0;
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      seen_valid = seen_valid | rsp_valid;
    end
    n_checks++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL mid_dropped: rsp_valid seen=%b, required 0", seen_valid); end
    send(2'd1, $urandom, $urandom, 1'b0);
    pop_one();
    n_checks++; if (txn_count !== 16'd1) begin n_fail++; $display("FAIL mid_resume_txn: got %0d, required 1", txn_count); end
  endtask

  initial begin
    reset = 1'b0; fault = 1'b0;
    cmd_valid = 1'b0; cmd_func = 2'd0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    s_cmd_valid = 1'b0; s_cmd_func = 2'd0; s_cmd_a = '0; s_cmd_b = '0; s_rsp_ready = 1'b0;
    m_txn = 16'd0; m_err = 16'd0;
    test_reset();
    test_add();
    test_sequence();
    test_wrap();
    test_backpressure();
    test_fault();
    m_err = 16'd1;
    test_small_cnt();
    test_random();
    test_reset_mid_drive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_driver.md
Name: alu_driver

Overview:
- Bus-functional initiator for the 2-bit-func combinational ALU (ports func, a, b, result).
- Accepts operation commands on a valid/ready stream and drives func/a/b to the ALU, holding them stable for one full clock.
- Samples result, checks it against an internal reference model, and returns responses through a buffered valid/ready stream.
- Lets hardware test harnesses exercise the ALU without a simulator-side bench.

Parameters:
- WIDTH, 32: operand/result width.
- FIFO_DEPTH, 4: response FIFO entries; power of 2, >=2.
- CNT_WIDTH, 16: width of transaction and error counters.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_func  in  2  0=add, 1=sub, 2=or, 3=and.
- cmd_a  in  WIDTH  operand a.
- cmd_b  in  WIDTH  operand b.
- alu_func  out  2  to ALU func.
- alu_a  out  WIDTH  to ALU a.
- alu_b  out  WIDTH  to ALU b.
- alu_result  in  WIDTH  from ALU result.
- rsp_valid  out  1  response available (FIFO not empty).
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  WIDTH  sampled ALU result.
- rsp_func  out  2  func of that transaction.
- rsp_mismatch  out  1  result differed from reference model.
- txn_count  out  CNT_WIDTH  responses pushed since reset; wraps.
- err_count  out  CNT_WIDTH  mismatches since reset; saturates at all-ones.
- busy  out  1  high while state is DRIVE.

Behaviour:
- Reset (reset low at a rising edge):
  - state=IDLE.
  - alu_func/alu_a/alu_b=0.
  - FIFO emptied, so rsp_valid=0 and rsp_* read as 0.
  - txn_count=0, err_count=0, busy=0, cmd_ready=0 during reset.
  - Overrides everything, including a transaction in DRIVE; that transaction is dropped and produces no response.
- FSM IDLE:
  - cmd_ready = (fifo_count < FIFO_DEPTH). Combinational from registered state; must not depend on cmd_valid.
  - On cmd_valid && cmd_ready: register cmd_func/a/b into alu_func/a/b, go to DRIVE.
  - alu_* hold their last values while idle.
- FSM DRIVE (exactly one cycle):
  - cmd_ready=0, busy=1.
  - The ALU sees stable inputs for the whole cycle.
  - At the edge ending DRIVE: push {alu_result, alu_func, mismatch} into the FIFO, increment txn_count, go to IDLE.
- Reference model, computed from the registered alu_* values:
  - add = (a+b) mod 2^WIDTH.
  - sub = (a-b) mod 2^WIDTH.
  - or = a|b; and = a&b.
  - mismatch = (alu_result != expected). On mismatch, err_count increments unless already all-ones.
- Latency and throughput:
  - Command accepted at edge t.
  - alu_* valid after t.
  - Push at edge t+1.
  - rsp_valid high after t+1 if the FIFO was empty, so 2 cycles accept-to-response.
  - Peak throughput is 1 transaction per 2 cycles.
- FIFO:
  - First-word-fall-through; rsp_* present the head entry.
  - Pop on rsp_valid && rsp_ready.
  - Push (end of DRIVE) and pop in the same cycle are both performed; count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow is impossible: admission requires count < FIFO_DEPTH, and only one transaction is in flight.
- Full: with FIFO_DEPTH entries queued, cmd_ready=0 until a pop occurs. A pop in IDLE raises cmd_ready in the following cycle.
- Command changes: changes on cmd_* while cmd_ready=0 or while in DRIVE have no effect on alu_*.
- Empty: rsp_valid=0. rsp_ready is ignored.

Test Plan:
- Add: a=2, b=3, func=0, correct ALU attached -> rsp_result=5, rsp_func=0, rsp_mismatch=0, rsp_valid 2 cycles after accept, txn_count=1.
- Sequence: (5,3,add), then (1,3,and) -> responses 8 then 1 in order, err_count=0; cmd_ready low on each DRIVE cycle.
- Wrap: a=0, b=1, sub -> rsp_result=0xFFFFFFFF, mismatch=0. Then a=0xFFFFFFFF, b=1, add -> rsp_result=0, mismatch=0.
- Backpressure: rsp_ready=0, issue 5 commands.
  - 4 are accepted; cmd_ready stays 0 with 4 queued.
  - Raise rsp_ready for 1 cycle: one pop, cmd_ready=1 the next cycle, 5th command accepted.
  - All 5 results drain in issue order.
- Faulty ALU stub (result = correct+1): a=2, b=3, add -> rsp_result=6, rsp_mismatch=1, err_count=1.
  - Separately with CNT_WIDTH=2: 4 bad transactions leave err_count at 3, txn_count at 0 (wrapped).
- Reset mid-DRIVE: accept command, assert reset during DRIVE -> no response ever appears, FIFO empty, counters 0, alu_*=0. The next command after reset completes normally.
